seg7_scan_driver: RTL and testbench

Time-multiplexed driver for an N-digit common-anode seven-segment display. It holds a frame of hex nibbles with per-digit decimal points and blanking, then scans one digit at a time with a programmable refresh rate and anti-ghosting dead time. Each nibble is decoded to active-low segments. It sits between the game/score logic and the board display pins and replaces per-digit static decoding.

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seg7_hex_decode.sv | 14 +
 rtl/seg7_scan_driver.sv | 173 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment table,
// blank pattern and the digit-index width helper.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low a..g patterns (bit6=a, bit0=g); entry 15 first, entry 0 last.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };

  function automatic int unsigned idx_width(input int unsigned n);
    if (n <= 32'd1) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  // Table lookup covers all 16 codes, so no fallback is needed.
  always_comb begin
    seg_n = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with shadow/display
// double buffering. Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 65536,
  parameter int DEAD_CYCLES = 256
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [4*NUM_DIGITS-1:0]              value,
  input  logic [NUM_DIGITS-1:0]                dp,
  input  logic [NUM_DIGITS-1:0]                blank,
  input  logic                                 load,
  output logic [6:0]                           seg_n,
  output logic                                 dp_n,
  output logic [NUM_DIGITS-1:0]                an_n,
  output logic [idx_width(NUM_DIGITS)-1:0]     digit_idx,
  output logic                                 frame_tick
);

  localparam int PW = (REFRESH_DIV <= 2) ? 1 : $clog2(REFRESH_DIV);
  localparam int IW = idx_width(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] DEAD_END   = PW'(DEAD_CYCLES);
  localparam logic [IW-1:0] DIGIT_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]             presc_r;
  logic [IW-1:0]             digit_r;
  logic [4*NUM_DIGITS-1:0]   shadow_val_r;
  logic [NUM_DIGITS-1:0]     shadow_dp_r;
  logic [NUM_DIGITS-1:0]     shadow_blank_r;
  logic [4*NUM_DIGITS-1:0]   disp_val_r;
  logic [NUM_DIGITS-1:0]     disp_dp_r;
  logic [NUM_DIGITS-1:0]     disp_blank_r;
  logic                      pending_r;
  logic [6:0]                seg_n_r;
  logic                      dp_n_r;
  logic [NUM_DIGITS-1:0]     an_n_r;
  logic                      frame_tick_r;

  logic                      slot_end_s;
  logic                      frame_end_s;
  logic                      anode_on_s;
  logic [3:0]                nib_s;
  logic                      dp_sel_s;
  logic                      dark_s;
  logic [NUM_DIGITS-1:0]     an_sel_s;
  logic [NUM_DIGITS-1:0]     lzb_dark_s;
  logic [6:0]                dec_seg_s;

  assign slot_end_s  = (presc_r == PRESC_LAST);
  assign frame_end_s = slot_end_s && (digit_r == DIGIT_LAST);
  assign anode_on_s  = (presc_r >= DEAD_END);

  // Slot prescaler: counts 0..REFRESH_DIV-1 and wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= {PW{1'b0}};
    end else if (slot_end_s) begin
      presc_r <= {PW{1'b0}};
    end else begin
      presc_r <= presc_r + 1'b1;
    end
  end

  // Digit scan counter advances at each slot end, wrapping after the last digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_r <= {IW{1'b0}};
    end else if (slot_end_s) begin
      if (digit_r == DIGIT_LAST) begin
        digit_r <= {IW{1'b0}};
      end else begin
        digit_r <= digit_r + 1'b1;
      end
    end else begin
      digit_r <= digit_r;
    end
  end

  // Shadow capture and frame-aligned transfer to the display copy; a load on
  // the boundary bypasses the shadow so the new frame starts immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val_r   <= {(4*NUM_DIGITS){1'b0}};
      shadow_dp_r    <= {NUM_DIGITS{1'b0}};
      shadow_blank_r <= {NUM_DIGITS{1'b0}};
      disp_val_r     <= {(4*NUM_DIGITS){1'b0}};
      disp_dp_r      <= {NUM_DIGITS{1'b0}};
      disp_blank_r   <= {NUM_DIGITS{1'b0}};
      pending_r      <= 1'b0;
    end else if (load && frame_end_s) begin
      shadow_val_r   <= value;
      shadow_dp_r    <= dp;
      shadow_blank_r <= blank;
      disp_val_r     <= value;
      disp_dp_r      <= dp;
      disp_blank_r   <= blank;
      pending_r      <= 1'b0;
    end else if (load) begin
      shadow_val_r   <= value;
      shadow_dp_r    <= dp;
      shadow_blank_r <= blank;
      pending_r      <= 1'b1;
    end else if (frame_end_s && pending_r) begin
      disp_val_r     <= shadow_val_r;
      disp_dp_r      <= shadow_dp_r;
      disp_blank_r   <= shadow_blank_r;
      pending_r      <= 1'b0;
    end else begin
      pending_r      <= pending_r;
    end
  end

`ifdef SEG7_LZB_EN
  logic upper_zero_s;

  // A digit is dark when it and every digit above it hold zero; digit 0 is exempt.
  always_comb begin
    lzb_dark_s   = {NUM_DIGITS{1'b0}};
    upper_zero_s = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero_s  = upper_zero_s & (disp_val_r[4*i +: 4] == 4'h0);
      lzb_dark_s[i] = upper_zero_s;
    end
  end
`else
  assign lzb_dark_s = {NUM_DIGITS{1'b0}};
`endif

  // Select nibble, decimal point, darkness and anode for the scanned digit.
  always_comb begin
    nib_s    = 4'h0;
    dp_sel_s = 1'b0;
    dark_s   = 1'b0;
    an_sel_s = {NUM_DIGITS{1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_sel_s[i] = (digit_r == IW'(i));
      nib_s       = an_sel_s[i] ? disp_val_r[4*i +: 4] : nib_s;
      dp_sel_s    = an_sel_s[i] ? disp_dp_r[i] : dp_sel_s;
      dark_s      = an_sel_s[i] ? (disp_blank_r[i] | lzb_dark_s[i]) : dark_s;
    end
  end

  seg7_hex_decode u_decode (
    .nibble (nib_s),
    .seg_n  (dec_seg_s)
  );

  // Registered pin drivers; the anode stays off for the dead time of each slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n_r      <= SEG_OFF;
      dp_n_r       <= 1'b1;
      an_n_r       <= {NUM_DIGITS{1'b1}};
      frame_tick_r <= 1'b0;
    end else begin
      seg_n_r      <= dark_s ? SEG_OFF : dec_seg_s;
      dp_n_r       <= dark_s | ~dp_sel_s;
      an_n_r       <= anode_on_s ? ~an_sel_s : {NUM_DIGITS{1'b1}};
      frame_tick_r <= frame_end_s;
    end
  end

  assign seg_n      = seg_n_r;
  assign dp_n       = dp_n_r;
  assign an_n       = an_n_r;
  assign digit_idx  = digit_r;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios plus random
// loads, all outputs compared every cycle against a frame-level model.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int DC = 2;
  localparam int FR = ND * RD;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };
`ifdef SEG7_LZB_EN
  localparam logic [6:0] LZ_SEG = 7'h7F;
`else
  localparam logic [6:0] LZ_SEG = 7'h01;
`endif

  typedef struct {
    int          k;
    logic [15:0] v;
    logic [3:0]  d;
    logic [3:0]  b;
  } load_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  blank = 4'h0;
  logic        load = 1'b0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  load_t loads[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .DEAD_CYCLES(DC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp         (dp),
    .blank      (blank),
    .load       (load),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_seg"}, seg_n, 7'h7F);
    chk({tag, "_dp"}, dp_n, 1'b1);
    chk({tag, "_an"}, an_n, 4'hF);
    chk({tag, "_tick"}, frame_tick, 1'b0);
    chk({tag, "_idx"}, digit_idx, 2'd0);
  endtask

  // Outputs sampled after edge number cyc describe scan position cyc-1.
  task automatic check_cycle();
    int          k, presc, d, f;
    logic [15:0] v;
    logic [3:0]  pd, pb, nib, ean;
    logic        dark, edp;
    logic [6:0]  eseg;
    k = cyc - 1;
    presc = k % RD;
    d = (k / RD) % ND;
    f = k / FR;
    v = 16'h0; pd = 4'h0; pb = 4'h0;
    foreach (loads[j]) begin
      if (loads[j].k <= f * FR - 1) begin
        v = loads[j].v; pd = loads[j].d; pb = loads[j].b;
      end
    end
    nib = v[4*d +: 4];
    dark = pb[d];
`ifdef SEG7_LZB_EN
    if (d > 0 && (v >> (4*d)) == 16'h0) dark = 1'b1;
`endif
    eseg = dark ? 7'h7F : SEG_TAB[nib];
    edp  = dark ? 1'b1 : ~pd[d];
    ean  = (presc >= DC) ? ~(4'b0001 << d) : 4'hF;
    chk("seg_n", seg_n, eseg);
    chk("dp_n", dp_n, edp);
    chk("an_n", an_n, ean);
    chk("digit_idx", digit_idx, (cyc / RD) % ND);
    chk("frame_tick", frame_tick, (cyc % FR) == 0);
    chk("one_anode", $countones(~an_n) <= 1, 1'b1);
  endtask

  task automatic step();
    load_t l;
    if (load) begin
      l.k = cyc; l.v = value; l.d = dp; l.b = blank;
      loads.push_back(l);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst_n) check_cycle();
  endtask

  task automatic run_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v; dp = d; blank = b; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    #4;
    rst_n = 1'b1;
    cyc = 0;

    // First frame shows the cleared display, then 1234 with dp on digit 2.
    run_until(3);
    do_load(16'h1234, 4'b0100, 4'h0);
    chk("f0_d0_seg", seg_n, 7'h01);
    run_until(36);
    chk("f1_d0_seg", seg_n, 7'h4C);
    chk("f1_d0_an", an_n, 4'b1110);
    run_until(44);
    chk("f1_d1_seg", seg_n, 7'h06);
    run_until(52);
    chk("f1_d2_seg", seg_n, 7'h12);
    chk("f1_d2_dp", dp_n, 1'b0);
    run_until(60);
    chk("f1_d3_seg", seg_n, 7'h4F);
    chk("f1_d3_dp", dp_n, 1'b1);

    // Anode duty: 6 of every 8 cycles across three frames.
    run_until(64);
    for (int s = 0; s < 3 * ND; s++) begin
      cnt = 0;
      for (int j = 0; j < RD; j++) begin
        step();
        if (an_n !== 4'hF) cnt++;
      end
      chk("an_duty", cnt, 6);
    end

    // Two loads inside one frame: only the later one is ever displayed.
    run_until(165);
    do_load(16'hABCD, 4'h0, 4'h0);
    run_until(185);
    do_load(16'hEF01, 4'h0, 4'h0);
    run_until(196);
    chk("ef01_d0", seg_n, 7'h4F);
    run_until(204);
    chk("ef01_d1", seg_n, 7'h01);
    run_until(212);
    chk("ef01_d2", seg_n, 7'h38);
    run_until(220);
    chk("ef01_d3", seg_n, 7'h30);

    // Load exactly on the frame boundary takes effect in the next frame.
    run_until(223);
    do_load(16'h8888, 4'h0, 4'h0);
    run_until(228);
    chk("bnd_d0", seg_n, 7'h00);
    run_until(252);
    chk("bnd_d3", seg_n, 7'h00);

    // Leading-zero handling.
    run_until(230);
    do_load(16'h0050, 4'h0, 4'h0);
    run_until(260);
    chk("lz50_d0", seg_n, 7'h01);
    do_load(16'h0000, 4'h0, 4'h0);
    run_until(268);
    chk("lz50_d1", seg_n, 7'h24);
    run_until(276);
    chk("lz50_d2", seg_n, LZ_SEG);
    run_until(284);
    chk("lz50_d3", seg_n, LZ_SEG);
    run_until(292);
    chk("lz0_d0", seg_n, 7'h01);
    run_until(300);
    chk("lz0_d1", seg_n, LZ_SEG);

    // Random loads, dp and blanking.
    run_until(320);
    while (cyc < 960) begin
      value = 16'($urandom);
      dp    = 4'($urandom);
      blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      load  = ($urandom_range(0, 9) == 0);
      step();
    end
    load = 1'b0;
    do_load(16'h1234, 4'h0, 4'h0);

    // Asynchronous reset in the middle of slot 2.
    run_until(1010);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    #3;
    rst_n = 1'b1;
    cyc = 0;
    loads.delete();
    run_until(2);
    chk("rst_dead_an", an_n, 4'hF);
    run_until(3);
    chk("rst_first_an", an_n, 4'b1110);
    run_until(4);
    chk("rst_cleared_d0", seg_n, 7'h01);
    run_until(2 * FR);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
